qm_fetch: RTL and testbench
===========================

QM_FETCH -- requirements
Module: qm_fetch

Interface
REQ-001 Parameter RESET_PC, 32'hBFC0_0000, first PC fetched after reset.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 o_IMemReq  output  1  instruction-memory request valid.
REQ-005 o_IMemAddr  output  32  word-aligned fetch address.
REQ-006 i_IMemAck  input  1  memory accepts request; i_IMemData valid same cycle.
REQ-007 i_IMemData  input  32  instruction word.
REQ-008 ci_Stall  input  1  decode cannot accept; hold IF/ID register.
REQ-009 ci_Redirect  input  1  taken branch/jump from a later stage.
REQ-010 di_RedirectPC  input  32  redirect target; bits [1:0] ignored.
REQ-011 do_IR  output  32  registered instruction to decode.
REQ-012 do_PCPlus4  output  32  registered PC of do_IR plus 4.
REQ-013 do_Valid  output  1  do_IR holds a real instruction.

Function
REQ-014 PC SHALL be a 32-bit register; o_IMemAddr = {PC[31:2], 2'b00}; PC+4 wraps modulo 2^32.
REQ-015 States: FETCH (o_IMemReq=1), DRAIN (o_IMemReq=1, response discarded), HOLD (o_IMemReq=0, fetched word buffered).
REQ-016 o_IMemReq and o_IMemAddr SHALL remain stable from assertion until the cycle i_IMemAck=1.
REQ-017 FETCH, ack, no stall, no redirect: do_IR<=i_IMemData, do_PCPlus4<=PC+4, do_Valid<=1, PC<=PC+4, stay FETCH; next request issues the following cycle (1 instruction/cycle at zero-wait memory).
REQ-018 FETCH, no ack, no redirect, no stall: do_Valid<=0 (bubble), do_IR<=0 (NOP); PC unchanged.
REQ-019 ci_Stall=1 and ci_Redirect=0: do_IR, do_PCPlus4, do_Valid SHALL hold; an ack in FETCH stores the word in a 1-entry skid buffer, PC<=PC+4, go HOLD.
REQ-020 HOLD: o_IMemReq=0; when ci_Stall falls, buffered word moves to IF/ID (do_Valid<=1), go FETCH.
REQ-021 ci_Redirect=1 SHALL override ci_Stall: do_Valid<=0, do_IR<=0, skid buffer cleared, PC<={di_RedirectPC[31:2],2'b00}.
REQ-022 Redirect in FETCH with ack same cycle, or in HOLD: go FETCH at new PC next cycle.
REQ-023 Redirect in FETCH without ack: request already issued, so go DRAIN, holding the old address; on ack discard data, go FETCH at redirect PC.
REQ-024 Further redirect in DRAIN: PC updates to newest target; remain DRAIN until ack.
REQ-025 Only one request outstanding at any time; no ack SHALL be consumed while o_IMemReq=0.
REQ-026 do_Valid=0 SHALL always coincide with do_IR=32'h0000_0000.

Reset
REQ-027 sys_rst=1 at an edge: PC<=RESET_PC, state<=FETCH, do_IR<=0, do_PCPlus4<=0, do_Valid<=0, skid buffer empty.
REQ-028 o_IMemReq SHALL be 0 while sys_rst=1 and assert the first cycle after release with o_IMemAddr=RESET_PC.
REQ-029 Reset mid-request SHALL abandon it; memory subsystem is reset by the same sys_rst, so no drain is needed after reset.

Structure
REQ-030 RESET_PC default, NOP encoding (32'h0) and state encodings SHALL live in the shared qm_defs package/include.
REQ-031 IF/ID output register plus skid buffer SHALL be one sub-module, qm_ifid_reg; PC/FSM stays in qm_fetch.
REQ-032 Outputs do_IR, do_PCPlus4, do_Valid SHALL be directly flop-driven.

Verification
REQ-033 Reset release, ack tied high, data = address -> addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; do_Valid high from second cycle after release.
REQ-034 Ack after 3 wait cycles -> o_IMemAddr stable for 4 cycles, do_Valid=0 and do_IR=0 for 3 cycles, then one valid word.
REQ-035 ci_Stall high 4 cycles with ack high -> do_IR frozen, exactly one extra word buffered, o_IMemReq low in HOLD; on release words arrive in order, none lost or duplicated.
REQ-036 Redirect to 0x00400013 while request pending, ack 2 cycles later -> stale word never valid; next address 0x00400010.
REQ-037 ci_Redirect and ci_Stall together -> do_Valid=0 next cycle, fetch resumes at target.
REQ-038 Redirect to 0xFFFFFFFC, ack high -> next address 0x00000000, do_PCPlus4 wraps to 0x00000000.

Source files
------------

// File: rtl/qm_defs.sv
// qm_defs: shared definitions for the instruction-fetch front end.
//   RESET_PC_DEFAULT : first PC fetched after reset
//   NOP              : encoding placed in IF/ID whenever it holds no instruction
//   fetch_state_t    : fetch FSM states
//   ifid_cmd_t       : per-cycle command from the fetch FSM to the IF/ID register
//   fetch_word_t     : instruction word paired with its PC+4
package qm_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request out, response goes to IF/ID
        ST_DRAIN = 2'd1,   // request out, response belongs to a squashed path
        ST_HOLD  = 2'd2    // no request, one word parked in the skid buffer
    } fetch_state_t;

    typedef enum logic [2:0] {
        IFID_KEEP    = 3'd0,   // hold everything
        IFID_LOAD    = 3'd1,   // take the incoming word into IF/ID
        IFID_BUBBLE  = 3'd2,   // IF/ID becomes an invalid NOP
        IFID_PARK    = 3'd3,   // IF/ID holds, incoming word goes to skid buffer
        IFID_UNPARK  = 3'd4,   // skid buffer moves into IF/ID
        IFID_FLUSH   = 3'd5    // squash IF/ID and skid buffer
    } ifid_cmd_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc_plus4;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/qm_ifid_reg.sv
// qm_ifid_reg: IF/ID pipeline register plus a one-entry skid buffer.
//   clk, rst  : clock, synchronous active-high reset
//   cmd       : operation for this cycle (from the fetch FSM)
//   word      : incoming instruction word and its PC+4
//   ir        : registered instruction (NOP when not valid)
//   pc_plus4  : registered PC+4 of ir
//   valid     : ir holds a real instruction
module qm_ifid_reg
    import qm_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ifid_cmd_t   cmd,
    input  fetch_word_t word,
    output logic [31:0] ir,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    fetch_word_t skid;
    logic        skid_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= NOP;
            pc_plus4  <= '0;
            valid     <= 1'b0;
            skid      <= '0;
            skid_full <= 1'b0;
        end else begin
            case (cmd)
                IFID_LOAD: begin
                    ir       <= word.ir;
                    pc_plus4 <= word.pc_plus4;
                    valid    <= 1'b1;
                end
                IFID_BUBBLE: begin
                    ir    <= NOP;
                    valid <= 1'b0;
                end
                IFID_PARK: begin
                    skid      <= word;
                    skid_full <= 1'b1;
                end
                IFID_UNPARK: begin
                    // An empty buffer still yields a NOP so ir/valid never disagree.
                    ir        <= skid_full ? skid.ir : NOP;
                    pc_plus4  <= skid.pc_plus4;
                    valid     <= skid_full;
                    skid_full <= 1'b0;
                end
                IFID_FLUSH: begin
                    ir        <= NOP;
                    valid     <= 1'b0;
                    skid_full <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qm_fetch.sv
// qm_fetch: instruction-fetch stage. Owns the PC and the fetch FSM and feeds
// the IF/ID register (qm_ifid_reg).
//   sys_clk, sys_rst  : clock, synchronous active-high reset
//   o_IMemReq/Addr    : instruction-memory request and word-aligned address
//   i_IMemAck/Data    : memory accept and same-cycle instruction word
//   ci_Stall          : decode cannot accept, hold IF/ID
//   ci_Redirect       : taken branch/jump, target on di_RedirectPC
//   do_IR/PCPlus4/Valid : registered instruction, its PC+4 and valid flag
module qm_fetch
    import qm_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemAck,
    input  logic [31:0] i_IMemData,
    input  logic        ci_Stall,
    input  logic        ci_Redirect,
    input  logic [31:0] di_RedirectPC,
    output logic [31:0] do_IR,
    output logic [31:0] do_PCPlus4,
    output logic        do_Valid
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  drain_addr, drain_addr_nx;
    logic [31:0]  fetch_addr;
    logic         ack;
    ifid_cmd_t    cmd;
    fetch_word_t  word;

    assign fetch_addr = word_align(pc);

    // In DRAIN the PC already points at the redirect target while the old
    // request is still on the bus, so the bus address comes from drain_addr.
    assign o_IMemReq  = (state != ST_HOLD) && !sys_rst;
    assign o_IMemAddr = (state == ST_DRAIN) ? drain_addr : fetch_addr;

    // An ack only counts against a live request.
    assign ack = i_IMemAck && o_IMemReq;

    assign word = '{ir: i_IMemData, pc_plus4: pc + 32'd4};

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            drain_addr <= drain_addr_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (ci_Redirect)
                    state_nx = ack ? ST_FETCH : ST_DRAIN;
                else if (ack && ci_Stall)
                    state_nx = ST_HOLD;
            end
            ST_DRAIN: if (ack) state_nx = ST_FETCH;
            ST_HOLD:  if (ci_Redirect || !ci_Stall) state_nx = ST_FETCH;
            default:  state_nx = ST_FETCH;
        endcase
    end

    // Output / datapath control
    always_comb begin
        cmd           = IFID_KEEP;
        pc_nx         = pc;
        drain_addr_nx = drain_addr;
        if (ci_Redirect) begin
            // Redirect wins over stall; anything fetched so far is wrong-path.
            cmd   = IFID_FLUSH;
            pc_nx = word_align(di_RedirectPC);
            if (state == ST_FETCH && !ack)
                drain_addr_nx = fetch_addr;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ack) begin
                        pc_nx = pc + 32'd4;
                        cmd   = ci_Stall ? IFID_PARK : IFID_LOAD;
                    end else if (!ci_Stall) begin
                        cmd = IFID_BUBBLE;
                    end
                end
                ST_DRAIN: if (!ci_Stall) cmd = IFID_BUBBLE;
                ST_HOLD:  if (!ci_Stall) cmd = IFID_UNPARK;
                default: ;
            endcase
        end
    end

    qm_ifid_reg u_ifid (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .cmd      (cmd),
        .word     (word),
        .ir       (do_IR),
        .pc_plus4 (do_PCPlus4),
        .valid    (do_Valid)
    );

endmodule

// File: tb/tb_qm_fetch.sv
// tb_qm_fetch: directed scenarios followed by randomized traffic. The memory
// returns each word's own address as its data. The reference model is the
// program-order stream: starting at the reset PC or the latest redirect
// target, decode must consume consecutive words PC, PC+4, ... A monitor pops
// that stream whenever decode consumes (valid, no stall, no redirect) and
// also checks bus stability and the bubble/NOP rule every cycle.
module tb_qm_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemAck = 1'b0;
    logic [31:0] i_IMemData;
    logic        ci_Stall = 1'b0;
    logic        ci_Redirect = 1'b0;
    logic [31:0] di_RedirectPC = 32'h0;
    logic [31:0] do_IR;
    logic [31:0] do_PCPlus4;
    logic        do_Valid;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] seg_next;

    qm_fetch dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .o_IMemReq     (o_IMemReq),
        .o_IMemAddr    (o_IMemAddr),
        .i_IMemAck     (i_IMemAck),
        .i_IMemData    (i_IMemData),
        .ci_Stall      (ci_Stall),
        .ci_Redirect   (ci_Redirect),
        .di_RedirectPC (di_RedirectPC),
        .do_IR         (do_IR),
        .do_PCPlus4    (do_PCPlus4),
        .do_Valid      (do_Valid)
    );

    always #5 sys_clk = ~sys_clk;

    assign i_IMemData = o_IMemAddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(seg_next);
            seg_next = seg_next + 32'd4;
        end
    endtask

    task automatic seg_start(input logic [31:0] target);
        exp_q.delete();
        seg_next = {target[31:2], 2'b00};
        refill();
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        refill();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        ci_Redirect   = 1'b1;
        di_RedirectPC = target;
        seg_start(target);
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising
    // edge will act on.
    initial begin : monitor
        logic        p_req, p_ack, p_rst;
        logic [31:0] p_addr, e;
        p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                chk("req_low_in_reset", {31'b0, o_IMemReq}, 32'd0);
            end else begin
                if (!do_Valid) chk("bubble_is_nop", do_IR, 32'h0);
                if (!p_rst && p_req && !p_ack) begin
                    chk("req_held", {31'b0, o_IMemReq}, 32'd1);
                    chk("addr_held", o_IMemAddr, p_addr);
                end
                if (do_Valid && !ci_Stall && !ci_Redirect) begin
                    consumed++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL stream_underflow: got %h expected none queued", do_IR);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_ir", do_IR, e);
                        chk("stream_pc4", do_PCPlus4, e + 32'd4);
                    end
                end
            end
            p_rst  = sys_rst;
            p_req  = o_IMemReq;
            p_ack  = i_IMemAck;
            p_addr = o_IMemAddr;
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        seg_start(RST_PC);
        repeat (2) step();
        chk("rst_req",   {31'b0, o_IMemReq}, 32'd0);
        chk("rst_valid", {31'b0, do_Valid},  32'd0);
        chk("rst_ir",    do_IR,      32'h0);
        chk("rst_pc4",   do_PCPlus4, 32'h0);

        // Release with ack tied high: one word per cycle.
        sys_rst = 1'b0; i_IMemAck = 1'b1; #1;
        chk("first_req",  {31'b0, o_IMemReq}, 32'd1);
        chk("first_addr", o_IMemAddr, 32'hBFC0_0000);
        step();
        chk("seq_addr1",  o_IMemAddr, 32'hBFC0_0004);
        chk("seq_valid1", {31'b0, do_Valid}, 32'd1);
        chk("seq_ir1",    do_IR, 32'hBFC0_0000);
        step();
        chk("seq_addr2",  o_IMemAddr, 32'hBFC0_0008);
        chk("seq_ir2",    do_IR, 32'hBFC0_0004);

        // Three wait states.
        i_IMemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr",  o_IMemAddr, 32'hBFC0_0008);
            chk("wait_valid", {31'b0, do_Valid}, 32'd0);
            chk("wait_ir",    do_IR, 32'h0);
        end
        i_IMemAck = 1'b1; #1;
        chk("wait_addr4", o_IMemAddr, 32'hBFC0_0008);
        step();
        chk("wait_word",  do_IR, 32'hBFC0_0008);
        chk("wait_valid_after", {31'b0, do_Valid}, 32'd1);

        // Stall for four cycles with ack high.
        ci_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ir",  do_IR, 32'hBFC0_0008);
            chk("stall_req", {31'b0, o_IMemReq}, 32'd0);
        end
        ci_Stall = 1'b0;
        step();
        chk("unstall_ir",   do_IR, 32'hBFC0_000C);
        chk("unstall_addr", o_IMemAddr, 32'hBFC0_0010);
        step();
        chk("unstall_ir2",  do_IR, 32'hBFC0_0010);

        // Redirect while a request is pending; ack two cycles later.
        i_IMemAck = 1'b0;
        step();
        redirect_to(32'h0040_0013);
        step();
        chk("drain_addr",  o_IMemAddr, 32'hBFC0_0014);
        chk("drain_valid", {31'b0, do_Valid}, 32'd0);
        ci_Redirect = 1'b0;
        step();
        chk("drain_addr2",  o_IMemAddr, 32'hBFC0_0014);
        chk("drain_valid2", {31'b0, do_Valid}, 32'd0);
        i_IMemAck = 1'b1;
        step();
        chk("drain_valid3", {31'b0, do_Valid}, 32'd0);
        chk("redir_addr",   o_IMemAddr, 32'h0040_0010);
        step();
        chk("redir_ir",  do_IR, 32'h0040_0010);
        chk("redir_pc4", do_PCPlus4, 32'h0040_0014);

        // Redirect and stall together.
        ci_Stall = 1'b1;
        redirect_to(32'h0000_1000);
        step();
        chk("rs_valid", {31'b0, do_Valid}, 32'd0);
        chk("rs_ir",    do_IR, 32'h0);
        chk("rs_addr",  o_IMemAddr, 32'h0000_1000);
        ci_Stall = 1'b0; ci_Redirect = 1'b0;
        step();
        chk("rs_ir2", do_IR, 32'h0000_1000);

        // PC wrap.
        redirect_to(32'hFFFF_FFFC);
        step();
        chk("wrap_addr", o_IMemAddr, 32'hFFFF_FFFC);
        ci_Redirect = 1'b0;
        step();
        chk("wrap_ir",   do_IR, 32'hFFFF_FFFC);
        chk("wrap_pc4",  do_PCPlus4, 32'h0);
        chk("wrap_next", o_IMemAddr, 32'h0);

        // Randomized traffic; acks may also arrive while no request is out.
        for (int n = 0; n < 4000; n++) begin
            i_IMemAck     = ($urandom_range(0, 99) < 65);
            ci_Stall      = ($urandom_range(0, 99) < 25);
            ci_Redirect   = 1'b0;
            di_RedirectPC = $urandom;
            if ($urandom_range(0, 99) < 3) begin
                tgt = $urandom;
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
                redirect_to(tgt);
            end
            if ($urandom_range(0, 999) < 3) begin
                sys_rst = 1'b1;
                seg_start(RST_PC);
            end else begin
                sys_rst = 1'b0;
            end
            step();
        end
        ci_Stall = 1'b0; ci_Redirect = 1'b0; sys_rst = 1'b0;
        step();
        chk("stream_progress", {31'b0, (consumed > 500)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
